// File: rtl/de1_soc_life_top.sv
// rtl/de1_soc_life_top.sv - 16x16 toroidal Game of Life with row-scanned LED matrix and hex status
module de1_soc_life_top #(
  parameter int SCAN_DIV_BITS = 4,
  parameter int RUN_DIV_BITS  = 6
) (
  input  logic        CLOCK_50,
  input  logic [9:0]  SW,
  input  logic [3:0]  KEY,
  output logic [9:0]  LEDR,
  output logic [6:0]  HEX0,
  output logic [6:0]  HEX1,
  output logic [6:0]  HEX2,
  output logic [6:0]  HEX3,
  output logic [6:0]  HEX4,
  output logic [6:0]  HEX5,
  output logic [35:0] GPIO_1
);

  typedef logic [15:0][15:0] grid_t;

  logic rst;
  assign rst = SW[8];

  logic unused_inputs;
  assign unused_inputs = ^{SW[9], SW[6:2], KEY[3], KEY[1]};

  // Index 0 tracks KEY[0] (step), index 1 tracks KEY[2] (load).
  logic [1:0] sync1_q, sync2_q, last_q, pulse_q;
  logic       step_pulse, load_pulse;

  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      sync1_q <= 2'b11;
      sync2_q <= 2'b11;
      last_q  <= 2'b11;
      pulse_q <= 2'b00;
    end else begin
      sync1_q <= {KEY[2], KEY[0]};
      sync2_q <= sync1_q;
      last_q  <= sync2_q;
      pulse_q <= last_q & ~sync2_q;
    end
  end

  assign step_pulse = pulse_q[0];
  assign load_pulse = pulse_q[1];

  logic [RUN_DIV_BITS-1:0] run_cnt_q;
  logic                    run_tick, step;

  always_ff @(posedge CLOCK_50) begin
    if (rst) run_cnt_q <= '0;
    else     run_cnt_q <= run_cnt_q + RUN_DIV_BITS'(1);
  end

  assign run_tick = &run_cnt_q;
  assign step     = step_pulse | (SW[7] & run_tick);

  function automatic logic next_cell(input grid_t g, input logic [3:0] r, input logic [3:0] c);
    logic [3:0] ru, rd, cl, cr, n;
    ru = r - 4'd1;
    rd = r + 4'd1;
    cl = c - 4'd1;
    cr = c + 4'd1;
    n = {3'd0, g[ru][cl]} + {3'd0, g[ru][c]} + {3'd0, g[ru][cr]}
      + {3'd0, g[r][cl]}                     + {3'd0, g[r][cr]}
      + {3'd0, g[rd][cl]} + {3'd0, g[rd][c]} + {3'd0, g[rd][cr]};
    next_cell = (n == 4'd3) || (g[r][c] && (n == 4'd2));
  endfunction

  function automatic grid_t seed_pattern(input logic [1:0] sel);
    seed_pattern = '0;
    case (sel)
      2'd0: begin
        seed_pattern[0] = 16'h0002;
        seed_pattern[1] = 16'h0004;
        seed_pattern[2] = 16'h0007;
      end
      2'd1: seed_pattern[7] = 16'h01C0;
      2'd2: begin
        seed_pattern[7] = 16'h0180;
        seed_pattern[8] = 16'h0180;
      end
      default: ;
    endcase
  endfunction

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;  4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;  4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;  4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;  4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
    endcase
  endfunction

  grid_t      grid_q, grid_d, prev_q, prev_d, next_grid;
  logic [7:0] gen_q, gen_d;
  logic [8:0] pop;

  always_comb begin
    next_grid = '0;
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++)
        next_grid[r][c] = next_cell(grid_q, 4'(r), 4'(c));
  end

  always_comb begin
    pop = '0;
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++)
        pop = pop + {8'd0, grid_q[r][c]};
  end

  // Load outranks step when both land in the same cycle.
  always_comb begin
    grid_d = grid_q;
    prev_d = prev_q;
    gen_d  = gen_q;
    if (load_pulse) begin
      grid_d = seed_pattern(SW[1:0]);
      prev_d = '0;
      gen_d  = 8'd0;
    end else if (step) begin
      prev_d = grid_q;
      grid_d = next_grid;
      gen_d  = gen_q + 8'd1;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      grid_q <= '0;
      prev_q <= '0;
      gen_q  <= 8'd0;
    end else begin
      grid_q <= grid_d;
      prev_q <= prev_d;
      gen_q  <= gen_d;
    end
  end

  logic [SCAN_DIV_BITS-1:0] scan_cnt_q;
  logic [3:0]               row_q;
  logic [35:0]              gpio_q;

  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      scan_cnt_q <= '0;
      row_q      <= 4'd0;
      gpio_q     <= '0;
    end else begin
      scan_cnt_q <= scan_cnt_q + SCAN_DIV_BITS'(1);
      if (&scan_cnt_q) row_q <= row_q + 4'd1;
      gpio_q <= {grid_q[row_q] & ~prev_q[row_q], grid_q[row_q], row_q};
    end
  end

  assign GPIO_1 = gpio_q;
  assign HEX0   = hex7(gen_q[3:0]);
  assign HEX1   = hex7(gen_q[7:4]);
  assign HEX2   = 7'h7F;
  assign HEX3   = hex7(pop[3:0]);
  assign HEX4   = hex7(pop[7:4]);
  assign HEX5   = hex7({3'd0, pop[8]});
  assign LEDR   = {SW[8], 7'd0, (pop == 9'd0), SW[7]};

endmodule

// File: tb/tb_de1_soc_life_top.sv
// tb/tb_de1_soc_life_top.sv - directed checks of seeds, stepping, free-run, priority and reset
module tb_de1_soc_life_top;

  logic        clk = 1'b0;
  logic [9:0]  SW;
  logic [3:0]  KEY;
  logic [9:0]  LEDR;
  logic [6:0]  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
  logic [35:0] GPIO_1;
  int total = 0;
  int bad = 0;

  de1_soc_life_top dut (
    .CLOCK_50(clk), .SW(SW), .KEY(KEY), .LEDR(LEDR),
    .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3), .HEX4(HEX4), .HEX5(HEX5),
    .GPIO_1(GPIO_1)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg(input logic [3:0] n);
    logic [6:0] font [16];
    font = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return font[n];
  endfunction

  task automatic press(input int k);
    @(negedge clk);
    KEY[k] = 1'b0;
    repeat (4) @(negedge clk);
    KEY[k] = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic read_row(input int r, output logic [15:0] red, output logic [15:0] green);
    bit found;
    found = 0;
    red = '0;
    green = '0;
    for (int i = 0; i < 600 && !found; i++) begin
      @(negedge clk);
      if (GPIO_1[3:0] == r[3:0]) begin
        red = GPIO_1[19:4];
        green = GPIO_1[35:20];
        found = 1;
      end
    end
    total++;
    if (!found) begin $display("FAIL row_scan row=%0d never shown", r); bad++; end
  endtask

  task automatic test_reset();
    SW = 10'h180;
    KEY = 4'hF;
    @(negedge clk);
    total++; if (LEDR[9] !== 1'b1) begin $display("FAIL reset_ledr9 got=%b want=1", LEDR[9]); bad++; end
    SW[8] = 1'b0;
    @(negedge clk);
    total++;
    if ({HEX5, HEX4, HEX3, HEX2, HEX1, HEX0} !== {7'h40, 7'h40, 7'h40, 7'h7F, 7'h40, 7'h40}) begin
      $display("FAIL reset_hex got=%h want=%h", {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0},
               {7'h40, 7'h40, 7'h40, 7'h7F, 7'h40, 7'h40}); bad++;
    end
    total++; if (LEDR !== 10'h003) begin $display("FAIL reset_ledr got=%h want=003", LEDR); bad++; end
    total++; if (GPIO_1 !== 36'd0) begin $display("FAIL reset_gpio got=%h want=0", GPIO_1); bad++; end
    SW[7] = 1'b0;
  endtask

  task automatic test_step_empty();
    SW = 10'h000;
    @(negedge clk);
    KEY[0] = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (HEX0 !== 7'h40) begin $display("FAIL step_latency_early got=%h want=40", HEX0); bad++; end
    @(negedge clk);
    total++; if (HEX0 !== 7'h79) begin $display("FAIL step_latency_n3 got=%h want=79", HEX0); bad++; end
    KEY[0] = 1'b1;
    repeat (8) @(negedge clk);
    total++; if ({HEX1, HEX0} !== {7'h40, 7'h79}) begin $display("FAIL step_once_gen got=%h want=%h", {HEX1, HEX0}, {7'h40, 7'h79}); bad++; end
    total++; if ({LEDR[1], HEX3} !== {1'b1, 7'h40}) begin $display("FAIL step_empty_pop got=%h want=%h", {LEDR[1], HEX3}, {1'b1, 7'h40}); bad++; end
  endtask

  task automatic test_load_glider();
    logic [15:0] red, green;
    logic [15:0] exp_rows [3];
    exp_rows = '{16'h0002, 16'h0004, 16'h0007};
    SW[1:0] = 2'd0;
    press(2);
    total++; if ({HEX1, HEX0} !== {7'h40, 7'h40}) begin $display("FAIL glider_gen got=%h want=%h", {HEX1, HEX0}, {7'h40, 7'h40}); bad++; end
    total++; if ({HEX5, HEX4, HEX3, LEDR[1]} !== {7'h40, 7'h40, seg(4'd5), 1'b0}) begin
      $display("FAIL glider_pop got=%h want=%h", {HEX5, HEX4, HEX3, LEDR[1]}, {7'h40, 7'h40, seg(4'd5), 1'b0}); bad++;
    end
    for (int r = 0; r < 3; r++) begin
      read_row(r, red, green);
      total++; if ({red, green} !== {exp_rows[r], exp_rows[r]}) begin
        $display("FAIL glider_row%0d got=%h want=%h", r, {red, green}, {exp_rows[r], exp_rows[r]}); bad++;
      end
    end
  endtask

  task automatic test_glider_evolution();
    logic [15:0] red, green;
    logic [15:0] exp_rows [5];
    exp_rows = '{16'h0000, 16'h0004, 16'h0008, 16'h000E, 16'h0000};
    repeat (4) press(0);
    total++; if ({HEX1, HEX0} !== {7'h40, seg(4'd4)}) begin $display("FAIL evo_gen got=%h want=%h", {HEX1, HEX0}, {7'h40, seg(4'd4)}); bad++; end
    total++; if (HEX3 !== seg(4'd5)) begin $display("FAIL evo_pop got=%h want=%h", HEX3, seg(4'd5)); bad++; end
    for (int r = 0; r < 5; r++) begin
      read_row(r, red, green);
      total++; if (red !== exp_rows[r]) begin $display("FAIL evo_row%0d got=%h want=%h", r, red, exp_rows[r]); bad++; end
    end
  endtask

  task automatic test_blinker();
    logic [15:0] red, green;
    logic [15:0] exp_green [3];
    exp_green = '{16'h0080, 16'h0000, 16'h0080};
    SW[1:0] = 2'd1;
    press(2);
    read_row(7, red, green);
    total++; if (red !== 16'h01C0) begin $display("FAIL blinker_seed got=%h want=01c0", red); bad++; end
    total++; if (HEX3 !== seg(4'd3)) begin $display("FAIL blinker_pop got=%h want=%h", HEX3, seg(4'd3)); bad++; end
    press(0);
    for (int r = 6; r < 9; r++) begin
      read_row(r, red, green);
      total++; if ({red, green} !== {16'h0080, exp_green[r-6]}) begin
        $display("FAIL blinker_row%0d got=%h want=%h", r, {red, green}, {16'h0080, exp_green[r-6]}); bad++;
      end
    end
    total++; if ({HEX0, HEX3} !== {seg(4'd1), seg(4'd3)}) begin $display("FAIL blinker_gen_pop got=%h want=%h", {HEX0, HEX3}, {seg(4'd1), seg(4'd3)}); bad++; end
  endtask

  task automatic test_empty_and_block();
    logic [15:0] red, green;
    SW[1:0] = 2'd3;
    press(2);
    total++; if ({LEDR[1], HEX3} !== {1'b1, 7'h40}) begin $display("FAIL empty_seed got=%h want=%h", {LEDR[1], HEX3}, {1'b1, 7'h40}); bad++; end
    SW[1:0] = 2'd2;
    press(2);
    press(0);
    total++; if ({HEX0, HEX3} !== {seg(4'd1), seg(4'd4)}) begin $display("FAIL block_step got=%h want=%h", {HEX0, HEX3}, {seg(4'd1), seg(4'd4)}); bad++; end
    read_row(8, red, green);
    total++; if ({red, green} !== {16'h0180, 16'h0000}) begin $display("FAIL block_row8 got=%h want=%h", {red, green}, {16'h0180, 16'h0000}); bad++; end
  endtask

  task automatic test_priority();
    logic [15:0] red, green;
    SW[1:0] = 2'd1;
    @(negedge clk);
    KEY[0] = 1'b0;
    KEY[2] = 1'b0;
    repeat (4) @(negedge clk);
    KEY[0] = 1'b1;
    KEY[2] = 1'b1;
    repeat (4) @(negedge clk);
    total++; if ({HEX1, HEX0} !== {7'h40, 7'h40}) begin $display("FAIL prio_gen got=%h want=%h", {HEX1, HEX0}, {7'h40, 7'h40}); bad++; end
    read_row(7, red, green);
    total++; if (red !== 16'h01C0) begin $display("FAIL prio_row7 got=%h want=01c0", red); bad++; end
  endtask

  task automatic test_free_run();
    logic [6:0] h;
    int n;
    SW[1:0] = 2'd2;
    press(2);
    SW[7] = 1'b1;
    @(negedge clk);
    total++; if (LEDR[0] !== 1'b1) begin $display("FAIL run_led got=%b want=1", LEDR[0]); bad++; end
    h = HEX0; n = 0;
    while (HEX0 === h && n < 200) begin @(negedge clk); n++; end
    total++; if (n >= 200) begin $display("FAIL run_first_tick got=%0d cycles want<200", n); bad++; end
    h = HEX0; n = 0;
    while (HEX0 === h && n < 200) begin @(negedge clk); n++; end
    total++; if (n != 64) begin $display("FAIL run_period got=%0d want=64", n); bad++; end
    n = 0;
    while ({HEX1, HEX0} !== {seg(4'hF), seg(4'hF)} && n < 20000) begin @(negedge clk); n++; end
    total++; if (n >= 20000) begin $display("FAIL run_reach_ff got=%0d cycles want<20000", n); bad++; end
    h = HEX0; n = 0;
    while (HEX0 === h && n < 200) begin @(negedge clk); n++; end
    total++; if ({HEX1, HEX0} !== {7'h40, 7'h40}) begin $display("FAIL gen_wrap got=%h want=%h", {HEX1, HEX0}, {7'h40, 7'h40}); bad++; end
    total++; if (HEX3 !== seg(4'd4)) begin $display("FAIL run_block_pop got=%h want=%h", HEX3, seg(4'd4)); bad++; end
  endtask

  task automatic test_reset_mid_run();
    repeat (100) @(negedge clk);
    total++; if ({HEX1, HEX0} === {7'h40, 7'h40}) begin $display("FAIL midrun_gen got=%h want=nonzero", {HEX1, HEX0}); bad++; end
    SW[8] = 1'b1;
    @(negedge clk);
    total++; if ({HEX1, HEX0, HEX3, LEDR} !== {7'h40, 7'h40, 7'h40, 10'h203}) begin
      $display("FAIL midrun_reset got=%h want=%h", {HEX1, HEX0, HEX3, LEDR}, {7'h40, 7'h40, 7'h40, 10'h203}); bad++;
    end
    total++; if (GPIO_1[35:4] !== 32'd0) begin $display("FAIL midrun_gpio got=%h want=0", GPIO_1[35:4]); bad++; end
    SW[8] = 1'b0;
    SW[7] = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_step_empty();
    test_load_glider();
    test_glider_evolution();
    test_blinker();
    test_empty_and_block();
    test_priority();
    test_free_run();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
